// File: rtl/keypad_if.sv
// Scanner <-> row/column decoder link plus the debounced key event outputs.
// master = keypad_scan side, slave = decoder / key consumer side.
interface keypad_if;
    logic       press;
    logic [3:0] scan_code;
    logic [2:0] sel;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  press,
        input  scan_code,
        output sel,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output press,
        output scan_code,
        input  sel,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// Row scan initiator for the 3x3 keypad decoder.
// Debounces press and release and emits one key event per physical press.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned NUM_ROWS     = 3
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned SEL_W = 3;
    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick_c;
    logic [CNT_W-1:0]   deb_q, deb_d, rel_q, rel_d;
    logic [KEY_W-1:0]   cand_q, cand_d, code_q, code_d;
    logic [SEL_W-1:0]   sel_q, sel_d, sel_next_c;
    logic               valid_q, valid_d, held_q, held_d;
    logic               cand_match_c, held_match_c;

    // Row dwell divider; inputs are only trusted on the last clock of a dwell.
    always_ff @(posedge clk) begin
        if (rst || tick_c) div_cnt <= '0;
        else               div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick_c       = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign sel_next_c   = (sel_q == SEL_W'(NUM_ROWS - 1)) ? '0 : sel_q + SEL_W'(1);
    assign cand_match_c = kp.press && (kp.scan_code == cand_q);
    assign held_match_c = kp.press && (kp.scan_code == code_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            deb_q   <= '0;
            rel_q   <= '0;
            cand_q  <= 4'hF;
            code_q  <= 4'hF;
            sel_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        rel_d   = rel_q;
        cand_d  = cand_q;
        code_d  = code_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            SCAN: begin
                if (tick_c) begin
                    if (kp.press) begin
                        cand_d = kp.scan_code;
                        deb_d  = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            code_d  = kp.scan_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        sel_d = sel_next_c;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick_c) begin
                    if (cand_match_c) begin
                        if (deb_q >= CNT_W'(DEBOUNCE_CNT - 1)) begin
                            deb_d   = CNT_W'(DEBOUNCE_CNT);
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end else begin
                            deb_d = deb_q + CNT_W'(1);
                        end
                    end else begin
                        deb_d   = '0;
                        sel_d   = sel_next_c;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                // A different code on the frozen row counts toward release, never a new event.
                if (tick_c) begin
                    if (held_match_c) begin
                        rel_d = '0;
                    end else if (rel_q >= CNT_W'(DEBOUNCE_CNT - 1)) begin
                        rel_d   = CNT_W'(DEBOUNCE_CNT);
                        held_d  = 1'b0;
                        sel_d   = sel_next_c;
                        state_d = SCAN;
                    end else begin
                        rel_d = rel_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.sel       = sel_q;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: decoder model, expected-event queue and a key_valid monitor.
module tb_keypad_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_if kp ();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .NUM_ROWS(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [2:0]  sel;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [2:0]  key_row = 3'd1;
    logic [2:0]  cols    = 3'b111;
    logic        prev_kv = 1'b0;

    // Decoder model: key codes 1..9 row-major, column bit 0 is the rightmost key.
    always_comb begin
        kp.press     = 1'b0;
        kp.scan_code = 4'hF;
        if (kp.sel == key_row && cols != 3'b111) begin
            kp.press = 1'b1;
            if (!cols[0])      kp.scan_code = 4'(key_row * 3 + 3);
            else if (!cols[1]) kp.scan_code = 4'(key_row * 3 + 2);
            else               kp.scan_code = 4'(key_row * 3 + 1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_event(input logic [3:0] code, input int unsigned after);
        exp_t e;
        e.code = code;
        e.sel  = 3'd1;
        e.cyc  = cyc + after;
        exp_q.push_back(e);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && kp.key_valid) begin
            check("kv_not_back_to_back", int'(prev_kv), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_key_valid: got code %0h expected no event (cycle %0d)",
                         kp.key_code, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_code", int'(kp.key_code), int'(e.code));
                check("event_sel", int'(kp.sel), int'(e.sel));
                check("event_held", int'(kp.key_held), 1);
                check("event_cycle", int'(cyc), int'(e.cyc));
            end
        end
        prev_kv <= kp.key_valid;
    end

    initial begin
        clocks(2);
        rst = 1'b0;
        check("rst_sel", int'(kp.sel), 0);
        check("rst_kv", int'(kp.key_valid), 0);
        check("rst_code", int'(kp.key_code), 15);
        check("rst_held", int'(kp.key_held), 0);

        // Idle scan: 0,1,2,0,1 with a 4-clock dwell
        begin
            int exp_sel[4] = '{1, 2, 0, 1};
            for (int i = 0; i < 4; i++) begin
                clocks(3);
                check("idle_sel_hold", int'(kp.sel), (i == 0) ? 0 : exp_sel[i-1]);
                clocks(1);
                check("idle_sel_step", int'(kp.sel), exp_sel[i]);
            end
        end
        check("idle_code", int'(kp.key_code), 15);

        // Press 6 at start of row-1 dwell: detect +4, accept +12
        cols = 3'b110;
        expect_event(4'h6, 12);
        clocks(8);
        check("frozen_sel", int'(kp.sel), 1);
        clocks(4);
        check("accept_code", int'(kp.key_code), 6);
        check("accept_held", int'(kp.key_held), 1);

        // Release: held drops on third empty tick
        cols = 3'b111;
        clocks(11);
        check("release_still_held", int'(kp.key_held), 1);
        clocks(1);
        check("release_held", int'(kp.key_held), 0);
        check("release_sel", int'(kp.sel), 2);

        // Re-press: row 1 reached at +8, accepted at +20
        cols = 3'b110;
        expect_event(4'h6, 20);
        clocks(20);
        check("repress_held", int'(kp.key_held), 1);

        // Switch to key 4 while held: counts as release, then 4 is detected from SCAN
        cols = 3'b011;
        clocks(12);
        check("switch_held", int'(kp.key_held), 0);
        check("switch_sel", int'(kp.sel), 2);
        check("switch_code", int'(kp.key_code), 6);
        expect_event(4'h4, 20);
        clocks(20);
        check("key4_code", int'(kp.key_code), 4);
        cols = 3'b111;
        clocks(12);
        check("key4_release", int'(kp.key_held), 0);

        // Bounce: one matching tick then nothing
        cols = 3'b110;
        clocks(12);
        cols = 3'b111;
        clocks(4);
        check("bounce_sel", int'(kp.sel), 2);
        check("bounce_code", int'(kp.key_code), 4);
        check("bounce_held", int'(kp.key_held), 0);

        // Reset with deb_cnt = 2
        cols = 3'b110;
        clocks(16);
        check("deb_frozen_sel", int'(kp.sel), 1);
        rst = 1'b1;
        clocks(1);
        rst  = 1'b0;
        cols = 3'b111;
        check("mid_rst_sel", int'(kp.sel), 0);
        check("mid_rst_held", int'(kp.key_held), 0);
        check("mid_rst_code", int'(kp.key_code), 15);
        check("mid_rst_kv", int'(kp.key_valid), 0);
        clocks(4);
        check("restart_sel", int'(kp.sel), 1);
        clocks(8);
        check("final_code", int'(kp.key_code), 15);
        check("pending_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
